// File: rtl/l1_d_cache_ctrl.sv
// L1 data-cache controller: tags, valid/dirty bits, round-robin replacement, write-back and refill sequencing.
// Defining L1D_PERF_CNT_EN adds saturating hit/miss/write-back counters on hit_cnt/miss_cnt/wb_cnt.
module l1_d_cache_ctrl #(
  parameter int unsigned TNUM  = 24,
  parameter int unsigned INUM  = 26 - TNUM,
  parameter int unsigned WAY   = 2,
  parameter int unsigned WBITS = $clog2(WAY)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             read_C_L1,
  input  logic             write_C_L1,
  input  logic [31:0]      address_C_L1,
  output logic             ready_L1_C,
  output logic             read_L1_L2,
  output logic             write_L1_L2,
  output logic [31:0]      address_L1_L2,
  input  logic             ready_L2_L1,
  output logic [INUM-1:0]  index_C_L1,
  output logic [5:0]       offset,
  output logic [WBITS-1:0] way,
  output logic             refill,
  output logic             update
`ifdef L1D_PERF_CNT_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt,
  output logic [31:0]      wb_cnt
`endif
);

  localparam int unsigned OFFW = 6;
  localparam int unsigned SETS = 1 << INUM;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_HIT,
    S_WB_RD,
    S_WB,
    S_FILL
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             wr_q, wr_d;
  logic [WBITS-1:0] victim_q, victim_d;
  logic             ready_q, ready_d;
  logic             rd_l2_q, rd_l2_d;
  logic             wr_l2_q, wr_l2_d;
  logic [31:0]      l2_addr_q, l2_addr_d;
  logic [WBITS-1:0] way_q, way_d;
  logic             update_q, update_d;

  logic [TNUM-1:0]  tag_q [SETS][WAY];
  logic [WAY-1:0]   valid_q [SETS];
  logic [WAY-1:0]   dirty_q [SETS];
  logic [WBITS-1:0] rr_q [SETS];

  logic [TNUM-1:0]  req_tag;
  logic [INUM-1:0]  set_idx;
  logic             hit_any;
  logic             inv_found;
  logic [WBITS-1:0] hit_way;
  logic [WBITS-1:0] vict_way;
  logic             set_dirty;
  logic             clr_dirty;
  logic             adv_rr;
  logic             fill_en;

  assign req_tag = addr_q[31 -: TNUM];
  assign set_idx = addr_q[OFFW +: INUM];

  // Tag compare across the set; victim is the lowest invalid way, else the round-robin pointer.
  always_comb begin
    hit_any   = 1'b0;
    inv_found = 1'b0;
    hit_way   = '0;
    vict_way  = rr_q[set_idx];
    for (int unsigned w = 0; w < WAY; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WBITS'(w);
      end
      if (!valid_q[set_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        vict_way  = WBITS'(w);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    victim_d  = victim_q;
    ready_d   = 1'b0;
    update_d  = 1'b0;
    rd_l2_d   = rd_l2_q;
    wr_l2_d   = wr_l2_q;
    l2_addr_d = l2_addr_q;
    way_d     = way_q;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    adv_rr    = 1'b0;
    fill_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_C_L1 || write_C_L1) begin
          addr_d  = address_C_L1;
          wr_d    = write_C_L1;
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        if (hit_any) begin
          way_d     = hit_way;
          ready_d   = 1'b1;
          update_d  = wr_q;
          set_dirty = wr_q;
          adv_rr    = 1'b1;
          state_d   = S_HIT;
        end else begin
          victim_d = vict_way;
          way_d    = vict_way;
          if (valid_q[set_idx][vict_way] && dirty_q[set_idx][vict_way]) begin
            state_d = S_WB_RD;
          end else begin
            rd_l2_d   = 1'b1;
            l2_addr_d = {req_tag, set_idx, 6'b0};
            state_d   = S_FILL;
          end
        end
      end
      S_HIT: begin
        state_d = S_IDLE;
      end
      S_WB_RD: begin
        wr_l2_d   = 1'b1;
        l2_addr_d = {tag_q[set_idx][victim_q], set_idx, 6'b0};
        state_d   = S_WB;
      end
      S_WB: begin
        if (ready_L2_L1) begin
          wr_l2_d   = 1'b0;
          clr_dirty = 1'b1;
          rd_l2_d   = 1'b1;
          l2_addr_d = {req_tag, set_idx, 6'b0};
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        if (ready_L2_L1) begin
          rd_l2_d = 1'b0;
          fill_en = 1'b1;
          state_d = S_TAG;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      victim_q  <= '0;
      ready_q   <= 1'b0;
      rd_l2_q   <= 1'b0;
      wr_l2_q   <= 1'b0;
      l2_addr_q <= '0;
      way_q     <= '0;
      update_q  <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      victim_q  <= victim_d;
      ready_q   <= ready_d;
      rd_l2_q   <= rd_l2_d;
      wr_l2_q   <= wr_l2_d;
      l2_addr_q <= l2_addr_d;
      way_q     <= way_d;
      update_q  <= update_d;
      if (fill_en) begin
        valid_q[set_idx][victim_q] <= 1'b1;
        dirty_q[set_idx][victim_q] <= 1'b0;
      end
      if (clr_dirty) dirty_q[set_idx][victim_q] <= 1'b0;
      if (set_dirty) dirty_q[set_idx][hit_way] <= 1'b1;
      if (adv_rr) rr_q[set_idx] <= hit_way + WBITS'(1);
    end
  end

  // Tag storage needs no reset; a tag is only trusted behind its valid bit.
  always_ff @(posedge clk) begin
    if (nrst && fill_en) tag_q[set_idx][victim_q] <= req_tag;
  end

  assign ready_L1_C    = ready_q;
  assign read_L1_L2    = rd_l2_q;
  assign write_L1_L2   = wr_l2_q;
  assign address_L1_L2 = l2_addr_q;
  assign index_C_L1    = set_idx;
  assign offset        = addr_q[OFFW-1:0];
  assign way           = way_q;
  assign update        = update_q;
  // L2 fill data is only present in the ready cycle, so refill decodes it directly.
  assign refill        = (state_q == S_FILL) && ready_L2_L1;

`ifdef L1D_PERF_CNT_EN
  logic        retry_q;
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  // retry_q marks the TAG visit that follows a refill so its hit is not counted again.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if ((state_q == S_FILL) && ready_L2_L1) retry_q <= 1'b1;
      else if (state_q == S_TAG) retry_q <= 1'b0;
      if ((state_q == S_TAG) && hit_any && !retry_q && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == S_TAG) && !hit_any && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 32'd1;
      if ((state_q == S_WB) && ready_L2_L1 && (wb_cnt_q != '1))
        wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_l1_d_cache_ctrl.sv
// Testbench for l1_d_cache_ctrl: directed scenarios plus randomized accesses against a set/way cache model.
module tb_l1_d_cache_ctrl;

  localparam int TNUM = 24;
  localparam int INUM = 2;
  localparam int WAY  = 2;
  localparam int SETS = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        read_C_L1, write_C_L1;
  logic [31:0] address_C_L1;
  logic        ready_L1_C, read_L1_L2, write_L1_L2;
  logic [31:0] address_L1_L2;
  logic        ready_L2_L1;
  logic [1:0]  index_C_L1;
  logic [5:0]  offset;
  logic        way;
  logic        refill, update;
`ifdef L1D_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_d_cache_ctrl dut (
    .clk           (clk),
    .nrst          (nrst),
    .read_C_L1     (read_C_L1),
    .write_C_L1    (write_C_L1),
    .address_C_L1  (address_C_L1),
    .ready_L1_C    (ready_L1_C),
    .read_L1_L2    (read_L1_L2),
    .write_L1_L2   (write_L1_L2),
    .address_L1_L2 (address_L1_L2),
    .ready_L2_L1   (ready_L2_L1),
    .index_C_L1    (index_C_L1),
    .offset        (offset),
    .way           (way),
    .refill        (refill),
    .update        (update)
`ifdef L1D_PERF_CNT_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .wb_cnt        (wb_cnt)
`endif
  );

  // Reference cache contents
  logic [TNUM-1:0] m_tag [SETS][WAY];
  bit              m_valid [SETS][WAY];
  bit              m_dirty [SETS][WAY];
  int              m_rr [SETS];
  int              m_hits, m_misses, m_wbs;

  bit          exp_hit, exp_wb;
  int          exp_way;
  logic [31:0] exp_wb_addr, exp_fill_addr;

  int          o_ready_t, o_refill_t, o_refill_n, o_upd_n, o_wb_t, o_fill_t, o_viol, o_extra;
  logic [31:0] o_wb_addr, o_fill_addr;
  logic        o_way, o_refill_way, o_upd_at_ready;
  logic [5:0]  o_off;
  logic [1:0]  o_idx;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAY; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_tag[s][w]   = '0;
      end
    end
    m_hits = 0; m_misses = 0; m_wbs = 0;
  endfunction

  // Predict the outcome of one access and commit its effect to the model.
  task automatic predict(input logic [31:0] a, input bit wr);
    int s, v;
    logic [TNUM-1:0] t;
    s = int'(a[6 +: INUM]);
    t = a[31 -: TNUM];
    exp_hit = 0; exp_wb = 0; exp_way = 0;
    for (int w = 0; w < WAY; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin exp_hit = 1; exp_way = w; end
    if (!exp_hit) begin
      v = -1;
      for (int w = WAY - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) v = m_rr[s];
      exp_way = v;
      if (m_valid[s][v] && m_dirty[s][v]) begin
        exp_wb = 1;
        exp_wb_addr = {m_tag[s][v], a[6 +: INUM], 6'b0};
        m_wbs++;
      end
      exp_fill_addr = {t, a[6 +: INUM], 6'b0};
      m_valid[s][v] = 1; m_tag[s][v] = t; m_dirty[s][v] = 0;
      m_misses++;
    end else begin
      m_hits++;
    end
    m_rr[s] = (exp_way + 1) % WAY;
    if (wr) m_dirty[s][exp_way] = 1;
  endtask

  // Issue one CPU request, act as L2 with the given latency, and record what the DUT did.
  task automatic run_access(input logic [31:0] a, input bit rd, input bit wr, input int lat);
    int l2_cnt, t;
    @(negedge clk);
    read_C_L1 = rd; write_C_L1 = wr; address_C_L1 = a;
    o_ready_t = -1; o_refill_t = -1; o_refill_n = 0; o_upd_n = 0; o_wb_t = -1; o_fill_t = -1;
    o_viol = 0; o_extra = 0; o_wb_addr = '0; o_fill_addr = '0; o_way = 0; o_refill_way = 0;
    o_upd_at_ready = 0; o_off = '0; o_idx = '0;
    l2_cnt = 0; t = 0;
    while (o_ready_t < 0 && t < 300) begin
      @(negedge clk);
      t++;
      ready_L2_L1 = 1'b0;
      if (read_L1_L2 || write_L1_L2) begin
        l2_cnt++;
        if (l2_cnt >= lat) begin ready_L2_L1 = 1'b1; l2_cnt = 0; end
      end else begin
        l2_cnt = 0;
        ready_L2_L1 = ($urandom_range(0, 3) == 0);
      end
      #1;
      if (write_L1_L2 && o_wb_t < 0) begin o_wb_t = t; o_wb_addr = address_L1_L2; end
      if (read_L1_L2 && o_fill_t < 0) begin o_fill_t = t; o_fill_addr = address_L1_L2; end
      if ((read_L1_L2 && write_L1_L2) || (refill && update)) o_viol++;
      if (refill) begin o_refill_n++; o_refill_t = t; o_refill_way = way; end
      if (update) o_upd_n++;
      if (ready_L1_C) begin
        o_ready_t = t; o_way = way; o_off = offset; o_idx = index_C_L1; o_upd_at_ready = update;
        read_C_L1 = 0; write_C_L1 = 0;
      end
    end
    read_C_L1 = 0; write_C_L1 = 0; ready_L2_L1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (ready_L1_C || update || refill || read_L1_L2 || write_L1_L2) o_extra++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; read_C_L1 = 0; write_C_L1 = 0; address_C_L1 = '0; ready_L2_L1 = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ready_L1_C, read_L1_L2, write_L1_L2, refill, update} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {ready_L1_C, read_L1_L2, write_L1_L2, refill, update});
    end
    checks++;
    if (address_L1_L2 !== 32'h0) begin errors++; $display("FAIL reset_l2_addr got %h exp 0", address_L1_L2); end
    checks++;
    if ({index_C_L1, offset, way} !== 9'h0) begin
      errors++; $display("FAIL reset_bram got %h exp 0", {index_C_L1, offset, way});
    end
    nrst = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_read();
    predict(32'h0000_0040, 0);
    run_access(32'h0000_0040, 1, 0, 4);
    checks++;
    if (o_fill_t !== 2) begin errors++; $display("FAIL cold_fill_time got %0d exp 2", o_fill_t); end
    checks++;
    if (o_fill_addr !== exp_fill_addr) begin errors++; $display("FAIL cold_fill_addr got %h exp %h", o_fill_addr, exp_fill_addr); end
    checks++;
    if (o_refill_n !== 1) begin errors++; $display("FAIL cold_refill_count got %0d exp 1", o_refill_n); end
    checks++;
    if (o_refill_way !== 1'(exp_way)) begin errors++; $display("FAIL cold_refill_way got %0d exp %0d", o_refill_way, exp_way); end
    checks++;
    if (o_ready_t !== o_refill_t + 2 || o_ready_t < 0) begin
      errors++; $display("FAIL cold_ready_time got %0d exp %0d", o_ready_t, o_refill_t + 2);
    end
    predict(32'h0000_0044, 0);
    run_access(32'h0000_0044, 1, 0, 3);
    checks++;
    if (o_ready_t !== 2) begin errors++; $display("FAIL hit_latency got %0d exp 2", o_ready_t); end
    checks++;
    if (o_fill_t !== -1 || o_refill_n !== 0) begin
      errors++; $display("FAIL hit_no_l2 got fill_t %0d refills %0d exp -1 0", o_fill_t, o_refill_n);
    end
  endtask

  task automatic test_store_hit();
    predict(32'h0000_0048, 1);
    run_access(32'h0000_0048, 0, 1, 3);
    checks++;
    if (o_upd_at_ready !== 1'b1 || o_upd_n !== 1) begin
      errors++; $display("FAIL store_update got at_ready %b count %0d exp 1 1", o_upd_at_ready, o_upd_n);
    end
    checks++;
    if (o_off !== 6'h08) begin errors++; $display("FAIL store_offset got %h exp 08", o_off); end
    checks++;
    if (o_way !== 1'(exp_way)) begin errors++; $display("FAIL store_way got %0d exp %0d", o_way, exp_way); end
  endtask

  task automatic test_dirty_evict();
    predict(32'h0100_0040, 0);
    run_access(32'h0100_0040, 1, 0, 2);
    checks++;
    if (o_wb_t !== -1 || o_fill_addr !== exp_fill_addr) begin
      errors++; $display("FAIL second_fill got wb_t %0d addr %h exp -1 %h", o_wb_t, o_fill_addr, exp_fill_addr);
    end
    predict(32'h0200_0040, 0);
    run_access(32'h0200_0040, 1, 0, 2);
    checks++;
    if (o_wb_t !== 3 || !exp_wb) begin errors++; $display("FAIL evict_wb_time got %0d exp 3", o_wb_t); end
    checks++;
    if (o_wb_addr !== exp_wb_addr) begin errors++; $display("FAIL evict_wb_addr got %h exp %h", o_wb_addr, exp_wb_addr); end
    checks++;
    if (o_fill_addr !== exp_fill_addr || o_fill_t <= o_wb_t) begin
      errors++; $display("FAIL evict_fill got %h at %0d exp %h after %0d", o_fill_addr, o_fill_t, exp_fill_addr, o_wb_t);
    end
    checks++;
    if (o_viol !== 0) begin errors++; $display("FAIL evict_exclusion got %0d exp 0", o_viol); end
  endtask

  task automatic test_rw_both();
    predict(32'h0200_0044, 1);
    run_access(32'h0200_0044, 1, 1, 2);
    checks++;
    if (o_upd_n !== 1 || o_ready_t !== 2) begin
      errors++; $display("FAIL both_as_store got updates %0d ready_t %0d exp 1 2", o_upd_n, o_ready_t);
    end
    checks++;
    if (o_extra !== 0) begin errors++; $display("FAIL both_extra_activity got %0d exp 0", o_extra); end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    logic [31:0] a;
    a = 32'h0300_0084;
    @(negedge clk);
    read_C_L1 = 1; address_C_L1 = a; ready_L2_L1 = 0;
    n = 0;
    while (!read_L1_L2 && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (!read_L1_L2) begin errors++; $display("FAIL midfill_no_fill got %b exp 1", read_L1_L2); end
    nrst = 1'b0; read_C_L1 = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({ready_L1_C, read_L1_L2, write_L1_L2, refill, update, way, index_C_L1, offset} !== 15'h0) begin
      errors++; $display("FAIL midfill_outputs got %h exp 0",
                         {ready_L1_C, read_L1_L2, write_L1_L2, refill, update, way, index_C_L1, offset});
    end
    checks++;
    if (address_L1_L2 !== 32'h0) begin errors++; $display("FAIL midfill_l2_addr got %h exp 0", address_L1_L2); end
    nrst = 1'b1;
    model_reset();
    predict(a, 0);
    run_access(a, 1, 0, 2);
    checks++;
    if (o_fill_t !== 2 || o_fill_addr !== exp_fill_addr) begin
      errors++; $display("FAIL midfill_reread got fill_t %0d addr %h exp 2 %h", o_fill_t, o_fill_addr, exp_fill_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int op, lat;
    bit rd, wr;
    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 2)) << 24) | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      op = $urandom_range(0, 3);
      rd = (op != 2);
      wr = (op >= 2);
      lat = $urandom_range(1, 5);
      predict(a, wr);
      run_access(a, rd, wr, lat);
      checks++;
      if (exp_hit && o_ready_t !== 2) begin errors++; $display("FAIL rnd%0d hit_latency got %0d exp 2", i, o_ready_t); end
      checks++;
      if (!exp_hit && (o_ready_t !== o_refill_t + 2 || o_ready_t < 0)) begin
        errors++; $display("FAIL rnd%0d miss_ready got %0d exp %0d", i, o_ready_t, o_refill_t + 2);
      end
      checks++;
      if (o_refill_n !== (exp_hit ? 0 : 1)) begin
        errors++; $display("FAIL rnd%0d refill_count got %0d exp %0d", i, o_refill_n, exp_hit ? 0 : 1);
      end
      checks++;
      if ((o_wb_t >= 0) !== exp_wb || (exp_wb && o_wb_addr !== exp_wb_addr)) begin
        errors++; $display("FAIL rnd%0d writeback got %0d %h exp %0d %h", i, o_wb_t, o_wb_addr, exp_wb, exp_wb_addr);
      end
      checks++;
      if (!exp_hit && o_fill_addr !== exp_fill_addr) begin
        errors++; $display("FAIL rnd%0d fill_addr got %h exp %h", i, o_fill_addr, exp_fill_addr);
      end
      checks++;
      if (o_way !== 1'(exp_way) || o_off !== a[5:0] || o_idx !== a[7:6]) begin
        errors++; $display("FAIL rnd%0d bram_sel got way %0d off %h idx %0d exp %0d %h %0d",
                           i, o_way, o_off, o_idx, exp_way, a[5:0], a[7:6]);
      end
      checks++;
      if (o_upd_n !== int'(wr) || o_upd_at_ready !== wr) begin
        errors++; $display("FAIL rnd%0d update got %0d exp %0d", i, o_upd_n, wr);
      end
      checks++;
      if (o_viol !== 0 || o_extra !== 0) begin
        errors++; $display("FAIL rnd%0d exclusion_extra got %0d %0d exp 0 0", i, o_viol, o_extra);
      end
    end
  endtask

`ifdef L1D_PERF_CNT_EN
  task automatic test_perf();
    checks++;
    if (hit_cnt !== 32'(m_hits)) begin errors++; $display("FAIL perf_hit got %0d exp %0d", hit_cnt, m_hits); end
    checks++;
    if (miss_cnt !== 32'(m_misses)) begin errors++; $display("FAIL perf_miss got %0d exp %0d", miss_cnt, m_misses); end
    checks++;
    if (wb_cnt !== 32'(m_wbs)) begin errors++; $display("FAIL perf_wb got %0d exp %0d", wb_cnt, m_wbs); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_read();
    test_store_hit();
    test_dirty_evict();
    test_rw_both();
    test_reset_mid_fill();
    test_random();
`ifdef L1D_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
